triangle_serializer: RTL and testbench

- Converts one assembled triangle (3 vertices × x/y/z plus RGB color) into a stream of 32-bit words for the AHB write-side buffer.
- It is the transmit-side counterpart of the triangle assembly path. Its packet body (words 1–10) uses the same word order that the assembly path consumes.
- It sits between the triangle producer and the AHB master write FIFO, and handles FIFO back-pressure.

---
 rtl/triangle_serializer.sv | 138 +++++++++++++
 tb/tb_triangle_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_serializer.sv
// triangle_serializer: turns one captured triangle into an 11-word packet for
// the AHB write-side FIFO and stalls cleanly under FIFO back-pressure.
// Packet: W0 = {SYNC_WORD, seq}, W1..W9 = v0.x..v2.z, W10 = {8'h00, r, g, b}.
// Ports:
//   clk, n_rst            - clock, synchronous active-low reset
//   triangle_valid        - producer offers a triangle
//   triangle_vertices_in  - 9 x 32-bit coordinates, v0.x in [31:0]
//   triangle_color_in     - {r, g, b}
//   triangle_accept       - triangle captured at this edge (combinational)
//   ahb_buffer_full       - FIFO cannot take a word this cycle
//   ahb_user_write_buffer - write strobe, one word per asserted cycle
//   ahb_wdata             - word being written (mux of registered data)
//   busy                  - packet in progress
//   packets_sent          - completed packet count, wraps
module triangle_serializer #(
  parameter logic [15:0] SYNC_WORD = 16'hA5A5,
  parameter int unsigned SEQ_W     = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             triangle_valid,
  input  logic [287:0]     triangle_vertices_in,
  input  logic [23:0]      triangle_color_in,
  output logic             triangle_accept,
  input  logic             ahb_buffer_full,
  output logic             ahb_user_write_buffer,
  output logic [31:0]      ahb_wdata,
  output logic             busy,
  output logic [SEQ_W-1:0] packets_sent
);

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned VERT_W   = 288;
  localparam int unsigned COLOR_W  = 24;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(10);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [SEQ_W-1:0]   seq_cap_q;
  logic [VERT_W-1:0]  vert_q;
  logic [COLOR_W-1:0] color_q;
  logic               capture;

  // Control state; packets_sent and the header sequence always move together,
  // so a single counter serves both.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
    end
  end

  // Capture registers need no reset: they are only read after a capture.
  // seq_d is latched so a back-to-back capture gets the post-increment value.
  always_ff @(posedge clk) begin
    if (capture) begin
      vert_q    <= triangle_vertices_in;
      color_q   <= triangle_color_in;
      seq_cap_q <= seq_d;
    end
  end

  // Next-state, accept and strobe logic.
  always_comb begin
    state_d               = state_q;
    idx_d                 = idx_q;
    seq_d                 = seq_q;
    capture               = 1'b0;
    triangle_accept       = 1'b0;
    ahb_user_write_buffer = 1'b0;
    busy                  = 1'b0;
    case (state_q)
      IDLE: begin
        triangle_accept = triangle_valid;
        if (triangle_valid) begin
          capture = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        busy                  = 1'b1;
        ahb_user_write_buffer = !ahb_buffer_full;
        if (!ahb_buffer_full) begin
          if (idx_q == LAST_IDX) begin
            seq_d = seq_q + SEQ_W'(1);
            idx_d = '0;
            // Chain the next triangle on the final-word cycle: no bubble.
            if (triangle_valid) begin
              triangle_accept = 1'b1;
              capture         = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word mux; driven only from registers so it is stable through stalls.
  always_comb begin
    ahb_wdata = '0;
    if (state_q == SEND) begin
      case (idx_q)
        4'd0:    ahb_wdata = {SYNC_WORD, 16'(seq_cap_q)};
        4'd1:    ahb_wdata = vert_q[0   +: 32];
        4'd2:    ahb_wdata = vert_q[32  +: 32];
        4'd3:    ahb_wdata = vert_q[64  +: 32];
        4'd4:    ahb_wdata = vert_q[96  +: 32];
        4'd5:    ahb_wdata = vert_q[128 +: 32];
        4'd6:    ahb_wdata = vert_q[160 +: 32];
        4'd7:    ahb_wdata = vert_q[192 +: 32];
        4'd8:    ahb_wdata = vert_q[224 +: 32];
        4'd9:    ahb_wdata = vert_q[256 +: 32];
        4'd10:   ahb_wdata = {8'h00, color_q};
        default: ahb_wdata = '0;
      endcase
    end
  end

  assign packets_sent = seq_q;

endmodule

// File: tb/tb_triangle_serializer.sv
// Bench for triangle_serializer: a 16-bit-sequence instance and a 2-bit one
// share all stimulus; each has its own expected-word queue and monitor.
module tb_triangle_serializer;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         valid;
  logic [287:0] vertices;
  logic [23:0]  color;
  logic         full;

  logic         acc, strobe, busy;
  logic [31:0]  wdata;
  logic [15:0]  pkts;
  logic         acc_w, strobe_w, busy_w;
  logic [31:0]  wdata_w;
  logic [1:0]   pkts_w;

  logic [31:0]  exp_q[$];
  logic [31:0]  exp_w_q[$];
  logic [15:0]  m_seq16;
  logic [1:0]   m_seq2;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  triangle_serializer #(.SYNC_WORD(16'hA5A5), .SEQ_W(16)) u_dut (
    .clk(clk), .n_rst(n_rst), .triangle_valid(valid),
    .triangle_vertices_in(vertices), .triangle_color_in(color),
    .triangle_accept(acc), .ahb_buffer_full(full),
    .ahb_user_write_buffer(strobe), .ahb_wdata(wdata),
    .busy(busy), .packets_sent(pkts)
  );

  triangle_serializer #(.SYNC_WORD(16'hA5A5), .SEQ_W(2)) u_dut_w (
    .clk(clk), .n_rst(n_rst), .triangle_valid(valid),
    .triangle_vertices_in(vertices), .triangle_color_in(color),
    .triangle_accept(acc_w), .ahb_buffer_full(full),
    .ahb_user_write_buffer(strobe_w), .ahb_wdata(wdata_w),
    .busy(busy_w), .packets_sent(pkts_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [287:0] mk(input int unsigned base);
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[32*i +: 32] = 32'(base + 32'(i) + 1);
    return r;
  endfunction

  task automatic push_pkt(input logic [287:0] v, input logic [23:0] c);
    exp_q.push_back({16'hA5A5, m_seq16});
    exp_w_q.push_back({16'hA5A5, 14'd0, m_seq2});
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(v[32*i +: 32]);
      exp_w_q.push_back(v[32*i +: 32]);
    end
    exp_q.push_back({8'h00, c});
    exp_w_q.push_back({8'h00, c});
    m_seq16 = m_seq16 + 16'd1;
    m_seq2  = m_seq2 + 2'd1;
  endtask

  // Offer a triangle; returns just after the accept edge with valid dropped.
  task automatic send_tri(input logic [287:0] v, input logic [23:0] c);
    bit found = 0;
    valid = 1'b1; vertices = v; color = c;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (acc) begin
        found = 1;
        chk("accept_lockstep", 32'(acc_w), 32'd1);
        push_pkt(v, c);
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
  endtask

  // Wait for both instances to drain and go idle.
  task automatic wait_idle(input string name);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!busy && !busy_w && exp_q.size() == 0 && exp_w_q.size() == 0) done = 1;
    end
    @(posedge clk); #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got left=%0d/%0d expected 0/0", name, exp_q.size(), exp_w_q.size());
    end
  endtask

  // Monitor: every strobe must match the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1) begin
        if (strobe) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_strobe: got word %h expected none", wdata);
          end else chk("word", wdata, exp_q.pop_front());
        end
        if (strobe_w) begin
          checks++;
          if (exp_w_q.size() == 0) begin
            errors++;
            $display("FAIL extra_strobe_w: got word %h expected none", wdata_w);
          end else chk("word_w", wdata_w, exp_w_q.pop_front());
        end
        if (!busy) begin
          chk("idle_strobe", 32'(strobe), 32'd0);
          chk("idle_wdata", wdata, 32'd0);
        end
      end
    end
  end

  initial begin
    int strobes, accs;
    n_rst = 1'b0; valid = 1'b0; vertices = '0; color = '0; full = 1'b0;
    m_seq16 = '0; m_seq2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_accept", 32'(acc), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_pkts", 32'(pkts), 32'd0);
    chk("rst_pkts_w", 32'(pkts_w), 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Idle hold
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_accept", 32'(acc), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_pkts", 32'(pkts), 32'd0);
    end
    @(posedge clk); #1;

    // Single packet: W0 appears the cycle after the accept edge
    send_tri(mk(0), 24'h112233);
    @(negedge clk);
    chk("latency_w0_strobe", 32'(strobe), 32'd1);
    chk("latency_w0_data", wdata, 32'hA5A5_0000);
    @(posedge clk); #1;
    wait_idle("single");
    chk("single_pkts", 32'(pkts), 32'd1);

    // Back-to-back: second accept on first packet's W10 strobe, 22 strobes
    send_tri(mk(100), 24'hAABBCC);
    valid = 1'b1; vertices = mk(200); color = 24'h445566;
    strobes = 0; accs = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (strobe) strobes++;
      if (acc) begin
        accs++;
        chk("b2b_accept_cycle", 32'(c), 32'd11);
        chk("b2b_accept_on_strobe", 32'(strobe), 32'd1);
        chk("b2b_accept_on_w10", wdata, 32'h00AA_BBCC);
        push_pkt(mk(200), 24'h445566);
      end
      @(posedge clk); #1;
      if (c == 11) valid = 1'b0;
    end
    chk("b2b_strobes", 32'(strobes), 32'd22);
    chk("b2b_accepts", 32'(accs), 32'd1);
    wait_idle("b2b");
    chk("b2b_pkts", 32'(pkts), 32'd3);

    // Back-pressure: stall on W3 for 4 cycles, then alternate
    send_tri(mk(0), 24'h112233);
    repeat (3) begin @(posedge clk); #1; end
    full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_stall_strobe", 32'(strobe), 32'd0);
      chk("bp_stall_hold", wdata, 32'h0000_0003);
      chk("bp_stall_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 12; i++) begin
      full = ~full;
      @(posedge clk); #1;
    end
    full = 1'b0;
    wait_idle("bp");
    chk("bp_pkts", 32'(pkts), 32'd4);

    // Reset during W5 abandons the packet
    send_tri(mk(300), 24'h778899);
    repeat (5) begin @(posedge clk); #1; end
    n_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_strobe", 32'(strobe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pkts", 32'(pkts), 32'd0);
    chk("midrst_pkts_w", 32'(pkts_w), 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    exp_q.delete(); exp_w_q.delete();
    m_seq16 = '0; m_seq2 = '0;
    send_tri(mk(400), 24'h0A0B0C);
    wait_idle("midrst");
    chk("midrst_after_pkts", 32'(pkts), 32'd1);

    // Sequence wrap on the 2-bit instance: headers 0,1,2,3,0
    for (int p = 1; p < 5; p++) send_tri(mk(500 + 10 * p), 24'(p * 24'h010203));
    wait_idle("wrap");
    chk("wrap_pkts", 32'(pkts), 32'd5);
    chk("wrap_pkts_w", 32'(pkts_w), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
